// File: rtl/mips_multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller_if
//
// Bundle between the multicycle MIPS control FSM and its datapath.
//   master modport : the controller (samples opcode/mem_ready, drives controls)
//   slave  modport : the datapath side (drives opcode/mem_ready, reads controls)
//
// Signals:
//   opcode        instruction-register opcode, sampled in DECODE
//   mem_ready     memory access completes this cycle
//   pc_write      unconditional PC update
//   branch_eq     PC update if ALU zero
//   branch_ne     PC update if ALU not zero
//   i_or_d        0 = PC address, 1 = ALU-out address
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   ir_write      instruction-register load
//   reg_dst       1 = rd, 0 = rt
//   mem_to_reg    1 = memory data, 0 = ALU-out
//   reg_write     register-file write
//   alu_src_a     0 = PC, 1 = reg A
//   alu_src_b     00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   pc_src        00 ALU result, 01 ALU-out, 10 jump target
//   alu_op        00 ADD, 01 SUB, 10 FUNCT, 11 ERR
//   illegal_op    illegal opcode decoded
//   halted        FSM in HALT
//   instr_retired one-cycle pulse per completed instruction
//   instr_count   retired-instruction count
// ---------------------------------------------------------------------------
interface mips_multicycle_controller_if #(
    parameter int OPCODE_W = 6,
    parameter int COUNT_W  = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                pc_write;
    logic                branch_eq;
    logic                branch_ne;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_src;
    logic [1:0]          alu_op;
    logic                illegal_op;
    logic                halted;
    logic                instr_retired;
    logic [COUNT_W-1:0]  instr_count;

    modport master (
        input  opcode, mem_ready,
        output pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               pc_src, alu_op, illegal_op, halted, instr_retired, instr_count
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, branch_eq, branch_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               pc_src, alu_op, illegal_op, halted, instr_retired, instr_count
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller
//
// Moore control FSM for a multicycle MIPS datapath. Each instruction walks
// FETCH -> DECODE -> class-specific execute/memory/writeback states, and the
// per-state control word is decoded from the state register. The only
// Mealy-style terms are the memory-completion strobes (ir_write/pc_write in
// FETCH, instr_retired in MEMWR), which are qualified by mem_ready.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   io_ctrl  controller side (master modport) of the control bundle:
//            opcode/mem_ready in, datapath controls + status/counter out
//
// Parameters:
//   OPCODE_W     opcode field width
//   MEM_WAIT_EN  1: memory states hold until mem_ready; 0: mem_ready ignored
//   BNE_EN       1: BNE is legal; 0: BNE decodes as illegal
//   ERR_HALT     1: illegal opcode parks in HALT; 0: returns to FETCH
//   COUNT_W      retired-instruction counter width (wraps)
// ---------------------------------------------------------------------------
module mips_multicycle_controller #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_WAIT_EN = 1,
    parameter int BNE_EN      = 0,
    parameter int ERR_HALT    = 1,
    parameter int COUNT_W     = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    mips_multicycle_controller_if.master io_ctrl
);

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_ERR   = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_ERR,
        S_HALT
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_is_sw;    // LW/SW choice for MEMADR
    logic                 r_is_bne;   // BEQ/BNE choice for BRANCH
    logic [COUNT_W-1:0]   r_instr_count;

    logic                 w_mem_ready;
    logic                 w_pc_write;
    logic                 w_branch_eq;
    logic                 w_branch_ne;
    logic                 w_i_or_d;
    logic                 w_mem_read;
    logic                 w_mem_write;
    logic                 w_ir_write;
    logic                 w_reg_dst;
    logic                 w_mem_to_reg;
    logic                 w_reg_write;
    logic                 w_alu_src_a;
    logic [1:0]           w_alu_src_b;
    logic [1:0]           w_pc_src;
    logic [1:0]           w_alu_op;
    logic                 w_illegal_op;
    logic                 w_halted;
    logic                 w_instr_retired;

    // With wait states disabled every memory access completes in one cycle.
    assign w_mem_ready = (MEM_WAIT_EN != 0) ? io_ctrl.mem_ready : 1'b1;

    // -----------------------------------------------------------------------
    // State, latched opcode class and retired-instruction counter
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_RST;
            r_is_sw       <= 1'b0;
            r_is_bne      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            // The opcode is only guaranteed valid in DECODE, so later states
            // that need to tell LW/SW or BEQ/BNE apart use these flags.
            if (r_state == S_DECODE) begin
                r_is_sw  <= (io_ctrl.opcode == OP_SW);
                r_is_bne <= (io_ctrl.opcode == OP_BNE);
            end
            if (w_instr_retired) begin
                r_instr_count <= r_instr_count + COUNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and per-state control word
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_write      = 1'b0;
        w_branch_eq     = 1'b0;
        w_branch_ne     = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = SRCB_REG;
        w_pc_src        = PCSRC_ALU;
        w_alu_op        = ALU_ADD;
        w_illegal_op    = 1'b0;
        w_halted        = 1'b0;
        w_instr_retired = 1'b0;

        case (r_state)
            S_RST: begin
                w_state_next = S_FETCH;
            end

            S_FETCH: begin
                // PC + 4 is computed every cycle; IR and PC only load when
                // the fetch read actually completes.
                w_mem_read  = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_alu_op    = ALU_ADD;
                w_pc_src    = PCSRC_ALU;
                w_ir_write  = w_mem_ready;
                w_pc_write  = w_mem_ready;
                if (w_mem_ready) begin
                    w_state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target precomputed into ALU-out.
                w_alu_src_b = SRCB_SHIMM;
                w_alu_op    = ALU_ADD;
                if (io_ctrl.opcode == OP_R) begin
                    w_state_next = S_EXECUTE;
                end else if (io_ctrl.opcode == OP_LW || io_ctrl.opcode == OP_SW) begin
                    w_state_next = S_MEMADR;
                end else if (io_ctrl.opcode == OP_BEQ) begin
                    w_state_next = S_BRANCH;
                end else if (io_ctrl.opcode == OP_BNE && BNE_EN != 0) begin
                    w_state_next = S_BRANCH;
                end else if (io_ctrl.opcode == OP_ADDI) begin
                    w_state_next = S_ADDIEX;
                end else if (io_ctrl.opcode == OP_J) begin
                    w_state_next = S_JUMP;
                end else begin
                    w_state_next = S_ERR;
                end
            end

            S_MEMADR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALU_ADD;
                w_state_next = r_is_sw ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                w_i_or_d   = 1'b1;
                w_mem_read = 1'b1;
                if (w_mem_ready) begin
                    w_state_next = S_MEMWB;
                end
            end

            S_MEMWB: begin
                w_mem_to_reg    = 1'b1;
                w_reg_write     = 1'b1;
                w_instr_retired = 1'b1;
                w_state_next    = S_FETCH;
            end

            S_MEMWR: begin
                // A store retires in the cycle its write is accepted.
                w_i_or_d        = 1'b1;
                w_mem_write     = 1'b1;
                w_instr_retired = w_mem_ready;
                if (w_mem_ready) begin
                    w_state_next = S_FETCH;
                end
            end

            S_EXECUTE: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_REG;
                w_alu_op     = ALU_FUNCT;
                w_state_next = S_ALUWB;
            end

            S_ALUWB: begin
                w_reg_dst       = 1'b1;
                w_reg_write     = 1'b1;
                w_instr_retired = 1'b1;
                w_state_next    = S_FETCH;
            end

            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = SRCB_REG;
                w_alu_op        = ALU_SUB;
                w_pc_src        = PCSRC_ALUOUT;
                w_branch_eq     = ~r_is_bne;
                w_branch_ne     = r_is_bne;
                w_instr_retired = 1'b1;
                w_state_next    = S_FETCH;
            end

            S_ADDIEX: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALU_ADD;
                w_state_next = S_ADDIWB;
            end

            S_ADDIWB: begin
                w_reg_write     = 1'b1;
                w_instr_retired = 1'b1;
                w_state_next    = S_FETCH;
            end

            S_JUMP: begin
                w_pc_src        = PCSRC_JUMP;
                w_pc_write      = 1'b1;
                w_instr_retired = 1'b1;
                w_state_next    = S_FETCH;
            end

            S_ERR: begin
                w_illegal_op = 1'b1;
                w_alu_op     = ALU_ERR;
                w_state_next = (ERR_HALT != 0) ? S_HALT : S_FETCH;
            end

            S_HALT: begin
                // Parked until reset; no strobes, status only.
                w_illegal_op = 1'b1;
                w_halted     = 1'b1;
                w_state_next = S_HALT;
            end

            default: begin
                w_state_next = S_RST;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Drive the bundle
    // -----------------------------------------------------------------------
    assign io_ctrl.pc_write      = w_pc_write;
    assign io_ctrl.branch_eq     = w_branch_eq;
    assign io_ctrl.branch_ne     = w_branch_ne;
    assign io_ctrl.i_or_d        = w_i_or_d;
    assign io_ctrl.mem_read      = w_mem_read;
    assign io_ctrl.mem_write     = w_mem_write;
    assign io_ctrl.ir_write      = w_ir_write;
    assign io_ctrl.reg_dst       = w_reg_dst;
    assign io_ctrl.mem_to_reg    = w_mem_to_reg;
    assign io_ctrl.reg_write     = w_reg_write;
    assign io_ctrl.alu_src_a     = w_alu_src_a;
    assign io_ctrl.alu_src_b     = w_alu_src_b;
    assign io_ctrl.pc_src        = w_pc_src;
    assign io_ctrl.alu_op        = w_alu_op;
    assign io_ctrl.illegal_op    = w_illegal_op;
    assign io_ctrl.halted        = w_halted;
    assign io_ctrl.instr_retired = w_instr_retired;
    assign io_ctrl.instr_count   = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_controller
//
// Three controllers with different parameter sets share one clock and one
// opcode/mem_ready drive; only the one under test is out of reset. Each
// instruction is expanded by the bench into its expected per-cycle control
// words (fetch with wait cycles, decode, class-specific phases), then the
// words are replayed and compared cycle by cycle together with the count.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] tb_opcode    = 6'h00;
    logic       tb_mem_ready = 1'b0;
    logic       rst_n_a = 1'b0, rst_n_b = 1'b0, rst_n_c = 1'b0;

    // A: defaults (wait states on, BNE illegal, halt on error, 32-bit count)
    // B: wait on, BNE legal, recover from error, 4-bit count
    // C: wait off, BNE illegal, recover from error, 8-bit count
    mips_multicycle_controller_if #(.OPCODE_W(6), .COUNT_W(32)) bus_a ();
    mips_multicycle_controller_if #(.OPCODE_W(6), .COUNT_W(4))  bus_b ();
    mips_multicycle_controller_if #(.OPCODE_W(6), .COUNT_W(8))  bus_c ();

    assign bus_a.opcode = tb_opcode;  assign bus_a.mem_ready = tb_mem_ready;
    assign bus_b.opcode = tb_opcode;  assign bus_b.mem_ready = tb_mem_ready;
    assign bus_c.opcode = tb_opcode;  assign bus_c.mem_ready = tb_mem_ready;

    mips_multicycle_controller #(.OPCODE_W(6), .MEM_WAIT_EN(1), .BNE_EN(0),
                                 .ERR_HALT(1), .COUNT_W(32))
        dut_a (.i_clk(clk), .i_rst_n(rst_n_a), .io_ctrl(bus_a));
    mips_multicycle_controller #(.OPCODE_W(6), .MEM_WAIT_EN(1), .BNE_EN(1),
                                 .ERR_HALT(0), .COUNT_W(4))
        dut_b (.i_clk(clk), .i_rst_n(rst_n_b), .io_ctrl(bus_b));
    mips_multicycle_controller #(.OPCODE_W(6), .MEM_WAIT_EN(0), .BNE_EN(0),
                                 .ERR_HALT(0), .COUNT_W(8))
        dut_c (.i_clk(clk), .i_rst_n(rst_n_c), .io_ctrl(bus_c));

    // Control word layout (bit 0 unused)
    localparam logic [20:0] PCW      = 21'h100000;
    localparam logic [20:0] BEQB     = 21'h080000;
    localparam logic [20:0] BNEB     = 21'h040000;
    localparam logic [20:0] IORD     = 21'h020000;
    localparam logic [20:0] MRD      = 21'h010000;
    localparam logic [20:0] MWR      = 21'h008000;
    localparam logic [20:0] IRW      = 21'h004000;
    localparam logic [20:0] RDST     = 21'h002000;
    localparam logic [20:0] M2R      = 21'h001000;
    localparam logic [20:0] RW       = 21'h000800;
    localparam logic [20:0] SRCA     = 21'h000400;
    localparam logic [20:0] SRCB_4   = 21'h000100;
    localparam logic [20:0] SRCB_IMM = 21'h000200;
    localparam logic [20:0] SRCB_SH  = 21'h000300;
    localparam logic [20:0] PCS_OUT  = 21'h000040;
    localparam logic [20:0] PCS_J    = 21'h000080;
    localparam logic [20:0] ALU_SUB  = 21'h000010;
    localparam logic [20:0] ALU_FN   = 21'h000020;
    localparam logic [20:0] ALU_ERR  = 21'h000030;
    localparam logic [20:0] ILL      = 21'h000008;
    localparam logic [20:0] HLT      = 21'h000004;
    localparam logic [20:0] RET      = 21'h000002;

    logic [20:0] obs_a, obs_b, obs_c, obs;
    logic [31:0] cnt_obs;
    int          sel = 0;

    assign obs_a = {bus_a.pc_write, bus_a.branch_eq, bus_a.branch_ne, bus_a.i_or_d,
                    bus_a.mem_read, bus_a.mem_write, bus_a.ir_write, bus_a.reg_dst,
                    bus_a.mem_to_reg, bus_a.reg_write, bus_a.alu_src_a, bus_a.alu_src_b,
                    bus_a.pc_src, bus_a.alu_op, bus_a.illegal_op, bus_a.halted,
                    bus_a.instr_retired, 1'b0};
    assign obs_b = {bus_b.pc_write, bus_b.branch_eq, bus_b.branch_ne, bus_b.i_or_d,
                    bus_b.mem_read, bus_b.mem_write, bus_b.ir_write, bus_b.reg_dst,
                    bus_b.mem_to_reg, bus_b.reg_write, bus_b.alu_src_a, bus_b.alu_src_b,
                    bus_b.pc_src, bus_b.alu_op, bus_b.illegal_op, bus_b.halted,
                    bus_b.instr_retired, 1'b0};
    assign obs_c = {bus_c.pc_write, bus_c.branch_eq, bus_c.branch_ne, bus_c.i_or_d,
                    bus_c.mem_read, bus_c.mem_write, bus_c.ir_write, bus_c.reg_dst,
                    bus_c.mem_to_reg, bus_c.reg_write, bus_c.alu_src_a, bus_c.alu_src_b,
                    bus_c.pc_src, bus_c.alu_op, bus_c.illegal_op, bus_c.halted,
                    bus_c.instr_retired, 1'b0};

    always_comb begin
        obs     = obs_a;
        cnt_obs = bus_a.instr_count;
        case (sel)
            1: begin obs = obs_b; cnt_obs = 32'(bus_b.instr_count); end
            2: begin obs = obs_c; cnt_obs = 32'(bus_c.instr_count); end
            default: ;
        endcase
    end

    // Reference model state
    bit          cfg_wait, cfg_bne, cfg_halt;
    logic [31:0] cnt_mask;
    logic [31:0] model_count;
    logic [20:0] exp_q[$];
    bit          rdy_q[$];
    logic [5:0]  op_q[$];
    string       tag_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic set_rst(input int which, input logic v);
        case (which)
            0: rst_n_a = v;
            1: rst_n_b = v;
            default: rst_n_c = v;
        endcase
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic push(input logic [20:0] w, input bit rdy, input logic [5:0] op,
                        input string tag);
        exp_q.push_back(w);
        rdy_q.push_back(rdy);
        op_q.push_back(op);
        tag_q.push_back(tag);
    endtask

    // Memory phase: 'waits' not-ready cycles (random when negative), then the
    // completing cycle which adds 'done_extra'.
    task automatic push_mem(input logic [20:0] base, input logic [20:0] done_extra,
                            input int waits, input string tag);
        int w;
        if (!cfg_wait)      w = 0;
        else if (waits < 0) w = int'($urandom_range(0, 3));
        else                w = waits;
        for (int i = 0; i < w; i++) push(base, 1'b0, rnd_op(), tag);
        push(base | done_extra, cfg_wait ? 1'b1 : 1'($urandom), rnd_op(), tag);
    endtask

    task automatic add_instr(input logic [5:0] op, input int wf, input int wm);
        string t;
        bit    illegal;
        t = $sformatf("op%02h", op);
        illegal = 1'b0;
        push_mem(MRD | SRCB_4, IRW | PCW, wf, {t, "_fetch"});
        push(SRCB_SH, 1'($urandom), op, {t, "_decode"});
        case (op)
            6'h00: begin
                push(SRCA | ALU_FN, 1'($urandom), rnd_op(), {t, "_exec"});
                push(RDST | RW | RET, 1'($urandom), rnd_op(), {t, "_aluwb"});
            end
            6'h23: begin
                push(SRCA | SRCB_IMM, 1'($urandom), rnd_op(), {t, "_memadr"});
                push_mem(IORD | MRD, 21'h0, wm, {t, "_memrd"});
                push(M2R | RW | RET, 1'($urandom), rnd_op(), {t, "_memwb"});
            end
            6'h2B: begin
                push(SRCA | SRCB_IMM, 1'($urandom), rnd_op(), {t, "_memadr"});
                push_mem(IORD | MWR, RET, wm, {t, "_memwr"});
            end
            6'h04: push(SRCA | ALU_SUB | PCS_OUT | BEQB | RET, 1'($urandom), rnd_op(),
                        {t, "_branch"});
            6'h05: begin
                if (cfg_bne) push(SRCA | ALU_SUB | PCS_OUT | BNEB | RET, 1'($urandom),
                                  rnd_op(), {t, "_branch"});
                else illegal = 1'b1;
            end
            6'h08: begin
                push(SRCA | SRCB_IMM, 1'($urandom), rnd_op(), {t, "_addiex"});
                push(RW | RET, 1'($urandom), rnd_op(), {t, "_addiwb"});
            end
            6'h02: push(PCS_J | PCW | RET, 1'($urandom), rnd_op(), {t, "_jump"});
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            push(ILL | ALU_ERR, 1'($urandom), rnd_op(), {t, "_err"});
            if (cfg_halt)
                for (int i = 0; i < 4; i++) push(ILL | HLT, 1'($urandom), rnd_op(), {t, "_halt"});
        end
    endtask

    // Replay the expected words; called on a falling edge. When abort_at
    // matches an entry index, reset is dropped between clock edges instead.
    task automatic run_queue(input int abort_at);
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            logic [20:0] e;
            string       tg;
            e            = exp_q.pop_front();
            tb_mem_ready = rdy_q.pop_front();
            tb_opcode    = op_q.pop_front();
            tg           = tag_q.pop_front();
            if (n == abort_at) begin
                set_rst(sel, 1'b0);
                #1;
                chk("abort_outputs", 32'(obs), 32'h0);
                chk("abort_count", cnt_obs, 32'h0);
                model_count = 0;
                exp_q.delete(); rdy_q.delete(); op_q.delete(); tag_q.delete();
                @(negedge clk);
                return;
            end
            #1;
            chk(tg, 32'(obs), 32'(e));
            chk({tg, "_count"}, cnt_obs, model_count);
            if ((e & RET) != 21'h0) model_count = (model_count + 1) & cnt_mask;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int which);
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        sel = which;
        case (which)
            0: begin cfg_wait = 1; cfg_bne = 0; cfg_halt = 1; cnt_mask = 32'hFFFF_FFFF; end
            1: begin cfg_wait = 1; cfg_bne = 1; cfg_halt = 0; cnt_mask = 32'h0000_000F; end
            default: begin cfg_wait = 0; cfg_bne = 0; cfg_halt = 0; cnt_mask = 32'h0000_00FF; end
        endcase
        model_count = 0;
        @(negedge clk);
        #1;
        chk("reset_outputs", 32'(obs), 32'h0);
        chk("reset_count", cnt_obs, 32'h0);
        set_rst(which, 1'b1);
        #1;
        chk("rst_state_outputs", 32'(obs), 32'h0);
        @(negedge clk);
    endtask

    logic [5:0] legal_ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    logic [5:0] all_ops[8]   = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F};

    initial begin
        // ---- A: directed R, LW with 3 waits, SW, BEQ
        do_reset(0);
        add_instr(6'h00, 0, 0);
        add_instr(6'h23, 0, 3);
        add_instr(6'h2B, 0, 0);
        add_instr(6'h04, 1, 0);
        run_queue(-1);
        chk("count_after_directed", cnt_obs, 32'd4);
        // ---- A: random legal stream
        for (int i = 0; i < 30; i++)
            add_instr(legal_ops[$urandom_range(0, 5)], -1, -1);
        run_queue(-1);
        // ---- A: reset in the middle of a MEMRD wait
        add_instr(6'h23, 0, 3);
        run_queue(4);
        // ---- A: BNE is illegal here -> ERR then HALT until reset
        do_reset(0);
        add_instr(6'h08, -1, -1);
        add_instr(6'h05, -1, -1);
        run_queue(-1);
        do_reset(0);
        add_instr(6'h02, 0, 0);
        run_queue(-1);
        chk("count_after_halt_reset", cnt_obs, 32'd1);

        // ---- B: 16 jumps wrap the 4-bit counter
        do_reset(1);
        for (int i = 0; i < 16; i++) add_instr(6'h02, -1, -1);
        run_queue(-1);
        chk("count_wrap", cnt_obs, 32'd0);
        add_instr(6'h05, -1, -1);
        add_instr(6'h3F, -1, -1);
        add_instr(6'h04, -1, -1);
        run_queue(-1);
        chk("count_after_err_recover", cnt_obs, 32'd2);
        for (int i = 0; i < 40; i++)
            add_instr(all_ops[$urandom_range(0, 7)], -1, -1);
        run_queue(-1);

        // ---- C: no wait states, mem_ready random and ignored
        do_reset(2);
        for (int i = 0; i < 40; i++)
            add_instr((i % 9 == 8) ? rnd_op() : all_ops[$urandom_range(0, 7)], -1, -1);
        run_queue(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Moore-style control FSM for the multicycle MIPS datapath, replacing single-cycle opcode decode.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives per-state datapath control plus ALU-op class.
- Adds optional memory wait states, optional BNE, configurable illegal-opcode handling, and a retired-instruction counter.

Parameters:
OPCODE_W, 6, opcode field width; encodings R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, BNE=0x05, ADDI=0x08, J=0x02 zero-extended into it.
MEM_WAIT_EN, 1, 1: FETCH/MEMRD/MEMWR hold until mem_ready; 0: mem_ready ignored, treated as 1.
BNE_EN, 0, 1: BNE opcode legal; 0: BNE treated as illegal.
ERR_HALT, 1, 1: illegal opcode enters HALT until reset; 0: one-cycle illegal_op pulse, then FETCH.
COUNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  instruction-register opcode, sampled in DECODE
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  unconditional PC update
branch_eq  out  1  PC update if ALU zero
branch_ne  out  1  PC update if ALU not zero
i_or_d  out  1  0 = PC address, 1 = ALU-out address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction-register load
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = memory data, 0 = ALU-out
reg_write  out  1  register-file write
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 shifted imm
pc_src  out  2  00 ALU result, 01 ALU-out, 10 jump target
alu_op  out  2  00 ADD, 01 SUB, 10 FUNCT, 11 ERR
illegal_op  out  1  illegal opcode decoded
halted  out  1  FSM in HALT
instr_retired  out  1  one-cycle pulse per completed instruction
instr_count  out  COUNT_W  retired-instruction count

Behaviour:
- Asynchronous reset: state=RST, instr_count=0. In RST every output is 0. RST -> FETCH on first clock after release.
- All control outputs decode from the state register only, except the ready-qualified strobes below. Unlisted outputs are 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=ADD, pc_src=00. ir_write and pc_write = mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_b=11, alu_op=ADD. Next state from opcode:
  - R -> EXECUTE
  - LW/SW -> MEMADR
  - BEQ -> BRANCH
  - BNE -> BRANCH if BNE_EN, else illegal
  - ADDI -> ADDIEX
  - J -> JUMP
  - other -> ERR
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next MEMRD (LW) or MEMWR (SW).
- MEMRD: i_or_d=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1 -> FETCH.
- MEMWR: i_or_d=1, mem_write=1. Hold until mem_ready, then FETCH.
- EXECUTE: alu_src_a=1, alu_op=FUNCT -> ALUWB.
- ALUWB: reg_dst=1, reg_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_op=SUB, pc_src=01. branch_eq=1 for BEQ, branch_ne=1 for BNE; opcode distinction is latched in DECODE. -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=ADD -> ADDIWB.
- ADDIWB: reg_write=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- ERR: illegal_op=1, alu_op=ERR for one cycle -> HALT if ERR_HALT, else FETCH.
- HALT: halted=1, illegal_op=1, all strobes 0. Only rst_n exits.
- mem_read/mem_write stay asserted through wait cycles; strobe in the completing cycle only when mem_ready=1.
- instr_retired pulses in MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, and the completing MEMWR cycle. Never in ERR.
- instr_count increments on instr_retired and wraps from all-ones to 0.
- Reset asserted mid-instruction or mid-wait aborts immediately to RST with count cleared.

Test Plan:
- Reset then R-type (opcode 0x00), mem_ready=1 -> RST, FETCH, DECODE, EXECUTE, ALUWB. ALUWB: reg_dst=1, reg_write=1, instr_retired=1, instr_count=1.
- LW (0x23) with MEM_WAIT_EN=1, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with mem_read=1, then MEMWB mem_to_reg=1. Total 5+3 cycles from FETCH.
- SW (0x2B) then BEQ (0x04) -> MEMWR mem_write=1, i_or_d=1, retire. BRANCH: branch_eq=1, alu_op=01, pc_src=01. instr_count=2.
- BNE (0x05) with BNE_EN=1 -> branch_ne=1, branch_eq=0. With BNE_EN=0 -> ERR, illegal_op=1, then HALT (halted=1) until rst_n low.
- Opcode 0x3F with ERR_HALT=0 -> ERR for one cycle, alu_op=11, then FETCH. instr_count unchanged.
- COUNT_W=4: retire 16 J (0x02) instructions (JUMP: pc_src=10, pc_write=1) -> count wraps 15->0. rst_n low mid-MEMRD -> all outputs 0 asynchronously.
